// File: rtl/matrix_frame_sequencer.sv
// rtl/matrix_frame_sequencer.sv - frame store and playback sequencer feeding the 6x6 LED matrix scan driver
// Optional feature macro: SEQ_PINGPONG_EN (bounce playback 0..last..0 instead of wrap-around).
module matrix_frame_sequencer #(
  parameter int NUM_FRAMES = 8,
  parameter int IDX_W      = 3,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [35:0]        wr_data,
  input  logic               play_en,
  input  logic [IDX_W-1:0]   last_frame,
  input  logic [DWELL_W-1:0] dwell,
  output logic [35:0]        img,
  output logic [IDX_W-1:0]   frame_idx,
  output logic               frame_start
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  logic [1:0]         state_q, state_d;
  // idx_q is the slot that the next LOAD fetches; it runs ahead of frame_idx_q.
  logic [IDX_W-1:0]   idx_q, idx_d;
  // last_frame as captured in LOAD, so one frame period sees a stable limit.
  logic [IDX_W-1:0]   last_q, last_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [35:0]        img_q, img_d;
  logic [IDX_W-1:0]   frame_idx_q, frame_idx_d;
  logic               frame_start_q, frame_start_d;

  logic [35:0]        store_q [NUM_FRAMES];
  logic               wr_en;
  logic [35:0]        rd_data;
  logic [DWELL_W-1:0] dwell_m1;
  logic               dwell_done;
  logic               advance;
  logic [IDX_W-1:0]   adv_idx;

`ifdef SEQ_PINGPONG_EN
  // 1 = counting up, 0 = counting down.
  logic               dir_q, dir_d;
  logic               adv_dir;
`endif

  // Store port and dwell comparison helpers.
  always_comb begin
    wr_ready   = (state_q != ST_LOAD);
    wr_en      = wr_valid & wr_ready & rst_n;
    rd_data    = store_q[idx_q];
    dwell_m1   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    // >= rather than == so a dwell shrunk below the running count still advances.
    dwell_done = (cnt_q >= dwell_m1);
    advance    = play_en & (state_q == ST_SHOW) & tick & dwell_done;
  end

  // Frame store write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store_q[wr_addr] <= wr_data;
    end
  end

`ifdef SEQ_PINGPONG_EN
  // Next slot in bounce order; endpoints are visited once per pass.
  always_comb begin
    adv_idx = idx_q;
    adv_dir = dir_q;
    if (last_q == '0) begin
      adv_idx = '0;
    end else if (idx_q > last_q) begin
      adv_idx = last_q;
      adv_dir = 1'b0;
    end else if (dir_q) begin
      if (idx_q == last_q) begin
        adv_idx = idx_q - IDX_W'(1);
        adv_dir = 1'b0;
      end else begin
        adv_idx = idx_q + IDX_W'(1);
      end
    end else begin
      if (idx_q == '0) begin
        adv_idx = IDX_W'(1);
        adv_dir = 1'b1;
      end else begin
        adv_idx = idx_q - IDX_W'(1);
      end
    end
  end

  // Direction restarts upward whenever playback restarts.
  always_comb begin
    dir_d = dir_q;
    if (!play_en || state_q == ST_IDLE) begin
      dir_d = 1'b1;
    end else if (advance) begin
      dir_d = adv_dir;
    end
  end

  // Direction register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q <= 1'b1;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  // Next slot in wrap order; >= also recovers when last_frame shrinks mid-play.
  always_comb begin
    adv_idx = (idx_q >= last_q) ? '0 : idx_q + IDX_W'(1);
  end
`endif

  // Playback FSM: IDLE -> LOAD -> SHOW -> LOAD ...; play_en low overrides everything.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    img_d         = img_q;
    frame_idx_d   = frame_idx_q;
    frame_start_d = 1'b0;
    if (!play_en) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      img_d       = '0;
      frame_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
        ST_LOAD: begin
          state_d       = ST_SHOW;
          img_d         = rd_data;
          frame_idx_d   = idx_q;
          frame_start_d = 1'b1;
          cnt_d         = '0;
          last_d        = last_frame;
        end
        ST_SHOW: begin
          if (tick) begin
            if (dwell_done) begin
              idx_d   = adv_idx;
              state_d = ST_LOAD;
            end else begin
              cnt_d = cnt_q + DWELL_W'(1);
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          cnt_d       = '0;
          img_d       = '0;
          frame_idx_d = '0;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      img_q         <= '0;
      frame_idx_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      img_q         <= img_d;
      frame_idx_q   <= frame_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign img         = img_q;
  assign frame_idx   = frame_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// tb/tb_matrix_frame_sequencer.sv - self-checking bench for matrix_frame_sequencer
module tb_matrix_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [35:0] wr_data;
  logic        play_en;
  logic [2:0]  last_frame;
  logic [7:0]  dwell;
  logic [35:0] img;
  logic [2:0]  frame_idx;
  logic        frame_start;

  int n_chk = 0;
  int n_err = 0;

  matrix_frame_sequencer #(.NUM_FRAMES(8), .IDX_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .play_en(play_en), .last_frame(last_frame),
    .dwell(dwell), .img(img), .frame_idx(frame_idx), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: play position, phase (0 idle, 1 fetching, 2 showing), ticks spent on frame.
  logic [35:0] m_mem [8];
  int          m_phase = 0;
  int          m_idx = 0;
  int          m_last = 0;
  int          m_cnt = 0;
  logic [35:0] m_img = '0;
  int          m_fidx = 0;
  logic        m_fs = 1'b0;
`ifdef SEQ_PINGPONG_EN
  logic        m_up = 1'b1;
`endif

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_advance();
`ifdef SEQ_PINGPONG_EN
    if (m_last == 0) m_idx = 0;
    else if (m_idx > m_last) begin m_idx = m_last; m_up = 1'b0; end
    else if (m_up) begin
      if (m_idx == m_last) begin m_up = 1'b0; m_idx = m_idx - 1; end
      else m_idx = m_idx + 1;
    end else begin
      if (m_idx == 0) begin m_up = 1'b1; m_idx = 1; end
      else m_idx = m_idx - 1;
    end
`else
    m_idx = (m_idx >= m_last) ? 0 : m_idx + 1;
`endif
  endtask

  task automatic model_step();
    logic [35:0] rd;
    int per;
    if (!rst_n) begin
      m_phase = 0; m_img = '0; m_fidx = 0; m_fs = 1'b0; m_cnt = 0; m_idx = 0; m_last = 0;
`ifdef SEQ_PINGPONG_EN
      m_up = 1'b1;
`endif
      return;
    end
    rd = m_mem[m_idx];
    if (wr_valid && m_phase != 1) m_mem[wr_addr] = wr_data;
    m_fs = 1'b0;
    per = (dwell == 8'd0) ? 1 : int'(dwell);
    if (!play_en) begin
      m_phase = 0; m_img = '0; m_fidx = 0; m_cnt = 0; m_idx = 0;
`ifdef SEQ_PINGPONG_EN
      m_up = 1'b1;
`endif
    end else if (m_phase == 0) begin
      m_phase = 1; m_idx = 0;
`ifdef SEQ_PINGPONG_EN
      m_up = 1'b1;
`endif
    end else if (m_phase == 1) begin
      m_img = rd; m_fidx = m_idx; m_fs = 1'b1; m_cnt = 0; m_last = int'(last_frame); m_phase = 2;
    end else if (tick) begin
      if (m_cnt + 1 >= per) begin m_advance(); m_phase = 1; end
      else m_cnt = m_cnt + 1;
    end
  endtask

  // One clock: model and DUT advance on the same edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_img", img, m_img);
    chk("model_idx", 36'(frame_idx), 36'(m_fidx));
    chk("model_fs", 36'(frame_start), 36'(m_fs));
    chk("model_wr_ready", 36'(wr_ready), 36'(m_phase != 1));
  endtask

  task automatic wait_fs(input int idx, input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      step();
      if (frame_start === 1'b1 && int'(frame_idx) == idx) return;
    end
    chk(name, 36'(frame_idx), 36'(idx));
    chk({name, "_timeout"}, 36'd0, 36'd1);
  endtask

  typedef struct {
    logic        rst_n, play_en, tick, wr_valid;
    logic [2:0]  wr_addr;
    logic [35:0] wr_data;
    logic [2:0]  last_frame;
    logic [7:0]  dwell;
    logic [35:0] e_img;
    logic [2:0]  e_idx;
    logic        e_fs, e_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic p, input logic t, input logic wv,
                              input logic [2:0] wa, input logic [35:0] wd, input logic [2:0] lf,
                              input logic [7:0] dw, input logic [35:0] ei, input logic [2:0] ex,
                              input logic efs, input logic ewr);
    vec_t v;
    v.rst_n = r; v.play_en = p; v.tick = t; v.wr_valid = wv; v.wr_addr = wa; v.wr_data = wd;
    v.last_frame = lf; v.dwell = dw; v.e_img = ei; v.e_idx = ex; v.e_fs = efs; v.e_wr = ewr;
    vecs.push_back(v);
  endfunction

  // Playback row with last_frame=2, dwell=3.
  function automatic void prow(input logic t, input logic [35:0] ei, input logic [2:0] ex,
                               input logic efs, input logic ewr);
    add(1'b1, 1'b1, t, 1'b0, 3'd0, 36'd0, 3'd2, 8'd3, ei, ex, efs, ewr);
  endfunction

  int exp_seq[8];
  int got;

  initial begin
    rst_n = 1'b0; tick = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    play_en = 1'b0; last_frame = '0; dwell = '0;

    // Reset, then idle with stray ticks, then fill every slot with a one-hot pattern.
    for (int i = 0; i < 2; i++)
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 36'd0, 3'd0, 8'd0, 36'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, 1'(i % 2), 1'b0, 3'd0, 36'd0, 3'd0, 8'd0, 36'd0, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b0, 1'b1, 3'(k), 36'h1 << k, 3'd0, 8'd0, 36'd0, 3'd0, 1'b0, 1'b1);
    // Play 0..2, each frame held for exactly 3 ticks; ticks during fetch are ignored.
    prow(1'b0, 36'h0, 3'd0, 1'b0, 1'b0);
    prow(1'b0, 36'h1, 3'd0, 1'b1, 1'b1);
    prow(1'b1, 36'h1, 3'd0, 1'b0, 1'b1);
    prow(1'b0, 36'h1, 3'd0, 1'b0, 1'b1);
    prow(1'b1, 36'h1, 3'd0, 1'b0, 1'b1);
    prow(1'b1, 36'h1, 3'd0, 1'b0, 1'b0);
    prow(1'b1, 36'h2, 3'd1, 1'b1, 1'b1);
    prow(1'b1, 36'h2, 3'd1, 1'b0, 1'b1);
    prow(1'b1, 36'h2, 3'd1, 1'b0, 1'b1);
    prow(1'b1, 36'h2, 3'd1, 1'b0, 1'b0);
    prow(1'b0, 36'h4, 3'd2, 1'b1, 1'b1);
    prow(1'b1, 36'h4, 3'd2, 1'b0, 1'b1);
    prow(1'b1, 36'h4, 3'd2, 1'b0, 1'b1);
    prow(1'b1, 36'h4, 3'd2, 1'b0, 1'b0);
    prow(1'b0, 36'h1, 3'd0, 1'b1, 1'b1);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; play_en = vecs[i].play_en; tick = vecs[i].tick;
      wr_valid = vecs[i].wr_valid; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      last_frame = vecs[i].last_frame; dwell = vecs[i].dwell;
      step();
      chk("tbl_img", img, vecs[i].e_img);
      chk("tbl_idx", 36'(frame_idx), 36'(vecs[i].e_idx));
      chk("tbl_fs", 36'(frame_start), 36'(vecs[i].e_fs));
      chk("tbl_wr_ready", 36'(wr_ready), 36'(vecs[i].e_wr));
    end
    wr_valid = 1'b0;

    // dwell=0 with a tick every cycle: fetch and show alternate, one frame per visit.
    play_en = 1'b0; step();
    play_en = 1'b1; tick = 1'b1; dwell = 8'd0; last_frame = 3'd2;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("d0_wr_vs_fs", 36'(wr_ready), 36'(frame_start));
      if (frame_start === 1'b1) begin
        chk("d0_idx", 36'(frame_idx), 36'(got % 3));
        got++;
      end
    end
    chk("d0_frame_count", 36'(got), 36'd6);

    // Rewrite the slot on display: img holds until that slot is fetched again.
    tick = 1'b0; play_en = 1'b0; step();
    play_en = 1'b1; dwell = 8'd3; last_frame = 3'd2;
    step(); step();
    chk("ws_first", img, 36'h1);
    tick = 1'b1;
    wait_fs(1, 20, "ws_reach1");
    tick = 1'b0; wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 36'hFFFFFFFFF;
    step();
    wr_valid = 1'b0;
    chk("ws_hold0", img, 36'h2);
    step(); step();
    chk("ws_hold1", img, 36'h2);
    tick = 1'b1;
    wait_fs(1, 40, "ws_revisit");
    chk("ws_new", img, 36'hFFFFFFFFF);

    // play_en drop wins over a simultaneous advancing tick.
    dwell = 8'd1; tick = 1'b1; play_en = 1'b0;
    step();
    chk("stop_img", img, 36'h0);
    chk("stop_idx", 36'(frame_idx), 36'd0);
    chk("stop_fs", 36'(frame_start), 36'd0);
    tick = 1'b0; play_en = 1'b1;
    step();
    chk("restart_load_img", img, 36'h0);
    chk("restart_load_wr", 36'(wr_ready), 36'd0);
    step();
    chk("restart_img", img, 36'h1);
    chk("restart_fs", 36'(frame_start), 36'd1);
    chk("restart_idx", 36'(frame_idx), 36'd0);

    // Play order over last_frame=3.
`ifdef SEQ_PINGPONG_EN
    exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    play_en = 1'b0; step();
    play_en = 1'b1; last_frame = 3'd3; dwell = 8'd1; tick = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 8; i++) begin
      step();
      if (frame_start === 1'b1) begin
        chk("order_idx", 36'(frame_idx), 36'(exp_seq[got]));
        got++;
      end
    end
    chk("order_count", 36'(got), 36'd8);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      play_en  = ($urandom_range(0, 59) != 0);
      tick     = ($urandom_range(0, 2) == 0);
      wr_valid = ($urandom_range(0, 7) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = {4'($urandom_range(0, 15)), 32'($urandom())};
      if ($urandom_range(0, 39) == 0) last_frame = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) dwell = 8'($urandom_range(0, 4));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
